// File: rtl/gray_conv_pkg.sv
// Shared definitions for the Gray-code conversion arbiter and its conversion unit.
package gray_conv_pkg;

  localparam int unsigned CODE_W = 4;

  // Direction encoding carried on req_mode/out_mode.
  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  typedef logic [CODE_W-1:0] code_t;

  // Ceiling log2, used to size requester IDs.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_code_unit.sv
// Combinational binary<->Gray converter; mode selects the direction.
module gray_code_unit
  import gray_conv_pkg::*;
(
  input  code_t code_in,
  input  logic  mode,
  output code_t code_out
);

  code_t b2g;
  code_t g2b;

  assign b2g = code_in ^ (code_in >> 1);

  // Gray->binary is a prefix XOR running from the MSB down.
  always_comb begin
    g2b = '0;
    g2b[CODE_W-1] = code_in[CODE_W-1];
    for (int k = CODE_W - 2; k >= 0; k--) begin
      g2b[k] = g2b[k+1] ^ code_in[k];
    end
  end

  assign code_out = (mode == MODE_G2B) ? g2b : b2g;

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray-code conversion unit among NREQ requesters.
// The converted result is registered and returned on a valid/ready channel with
// the requester ID and the direction used.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = CODE_W,
  parameter int unsigned IDW  = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_mode,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [IDW-1:0]    out_id,
  output logic              out_mode,
  input  logic              out_ready
);

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            out_valid_q;
  code_t           out_data_q;
  logic [IDW-1:0]  out_id_q;
  logic            out_mode_q;

  logic            load;
  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] grant;
  code_t           sel_data;
  logic            sel_mode;
  code_t           conv_data;

  assign load = !out_valid_q || out_ready;

  // Round-robin search: lowest valid index at or above rr_ptr wins, otherwise
  // wrap to the lowest valid index overall.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(rr_ptr_q))) begin
        grant_idx = IDW'(i);
      end
    end
  end

  assign grant     = grant_any ? (NREQ'(1) << grant_idx) : '0;
  assign req_ready = (rst_n && load) ? grant : '0;

  // Only the granted requester's fields reach the converter.
  always_comb begin
    sel_data = '0;
    sel_mode = MODE_B2G;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_any && (grant_idx == IDW'(i))) begin
        sel_data = req_data[i*W +: W];
        sel_mode = req_mode[i];
      end
    end
  end

  gray_code_unit u_gray_code_unit (
    .code_in  (sel_data),
    .mode     (sel_mode),
    .code_out (conv_data)
  );

  // Pointer moves to the slot just after the winner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (load && grant_any) begin
      rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  // Output register and pointer; stalled output holds everything stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_mode_q  <= MODE_B2G;
      rr_ptr_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (load) begin
        if (grant_any) begin
          out_valid_q <= 1'b1;
          out_data_q  <= conv_data;
          out_id_q    <= grant_idx;
          out_mode_q  <= sel_mode;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: directed table, corner sequences,
// exhaustive conversion sweep and randomized traffic against a behavioural model.
module tb_gray_conv_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_mode;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [IDW-1:0]    out_id;
  logic              out_mode;
  logic              out_ready;

  always #5 clk = ~clk;

  gray_conv_arbiter #(
    .NREQ (NREQ),
    .W    (W),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_mode  (out_mode),
    .out_ready (out_ready)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_valid, m_data, m_id, m_mode, m_ptr;
  int m_wait [NREQ];
  int m_grant;
  int last_ready;

  typedef struct {
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] e_ready;
    logic       e_valid;
    int         e_id;
    logic [3:0] e_data;
    logic       e_mode;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int b2g(input int x);
    return x ^ (x / 2);
  endfunction

  // Inverse by search over all codes, independent of any bitwise recurrence.
  function automatic int g2b(input int g);
    for (int b = 0; b < 16; b++) begin
      if (b2g(b) == g) return b;
    end
    return -1;
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_id = 0; m_mode = 0; m_ptr = 0;
    for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
  endtask

  // One clock: check combinational ready, advance model, check registered outputs.
  task automatic step();
    int g, ld, code, md;
    #1;
    ld = (m_valid == 0 || out_ready) ? 1 : 0;
    g  = model_grant();
    last_ready = (rst_n && ld && g >= 0) ? (1 << g) : 0;
    check("req_ready", int'(req_ready), last_ready);
    code = (g >= 0) ? int'(req_data[g*W +: W]) : 0;
    md   = (g >= 0) ? int'(req_mode[g]) : 0;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (ld) begin
      if (g >= 0) begin
        check("fairness_wait", (m_wait[g] <= NREQ - 1) ? 1 : 0, 1);
        for (int i = 0; i < NREQ; i++) begin
          if (i == g) m_wait[i] = 0;
          else if (req_valid[i]) m_wait[i]++;
          else m_wait[i] = 0;
        end
        m_valid = 1;
        m_id    = g;
        m_mode  = md;
        m_data  = md ? g2b(code) : b2g(code);
        m_ptr   = (g + 1) % NREQ;
      end else begin
        m_valid = 0;
      end
    end
    m_grant = (last_ready != 0) ? g : -1;
    #1;
    check("out_valid", int'(out_valid), m_valid);
    check("out_data", int'(out_data), m_data);
    check("out_id", int'(out_id), m_id);
    check("out_mode", int'(out_mode), m_mode);
  endtask

  initial begin
    int r, gcode;
    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 0, 4'b0111, 1'b0};
    tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 1, 4'b1111, 1'b1};
    tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2, 4'b1111, 1'b0};
    tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 3, 4'b0101, 1'b1};
    tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 0, 4'b0111, 1'b0};
    tbl[5]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 0, 4'b0111, 1'b0};
    tbl[6]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 0, 4'b0111, 1'b0};
    tbl[7]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 0, 4'b0111, 1'b0};
    tbl[8]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 1, 4'b1111, 1'b1};
    tbl[9]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2, 4'b1111, 1'b0};
    tbl[10] = '{4'h5, 1'b1, 4'b0001, 1'b1, 0, 4'b0111, 1'b0};
    tbl[11] = '{4'h5, 1'b1, 4'b0100, 1'b1, 2, 4'b1111, 1'b0};
    tbl[12] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2, 4'b1111, 1'b0};

    // Reset.
    rst_n = 1'b0; req_valid = '0; req_mode = '0; req_data = '0; out_ready = 1'b0;
    m_grant = -1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check("rst_ready", int'(req_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_id", int'(out_id), 0);
    check("rst_out_mode", int'(out_mode), 0);

    // Directed table: all-valid rotation, backpressure, wrap, idle.
    rst_n    = 1'b1;
    req_data = 16'h7A85;
    req_mode = 4'b1010;
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].valid;
      out_ready = tbl[i].ordy;
      step();
      check("tbl_ready", last_ready, int'(tbl[i].e_ready));
      check("tbl_valid", int'(out_valid), int'(tbl[i].e_valid));
      check("tbl_id", int'(out_id), tbl[i].e_id);
      check("tbl_data", int'(out_data), int'(tbl[i].e_data));
      check("tbl_mode", int'(out_mode), int'(tbl[i].e_mode));
    end

    // Reset mid-operation: pointer is moved away from 0 first.
    req_valid = 4'b1010; out_ready = 1'b1;
    step();
    check("pre_rst_id3", int'(out_id), 3);
    step();
    check("pre_rst_id1", int'(out_id), 1);
    out_ready = 1'b0;
    step();
    check("stall_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    step();
    check("mid_rst_ready", last_ready, 0);
    check("mid_rst_valid", int'(out_valid), 0);
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    check("post_rst_id", int'(out_id), 1);
    check("post_rst_data", int'(out_data), 15);

    // Exhaustive single-requester sweep with junk on the other requesters.
    for (int x = 0; x < 16; x++) begin
      r = x % NREQ;
      req_data = NREQ*W'($urandom);
      req_mode = NREQ'($urandom);
      req_mode[r] = 1'b0;
      req_data[r*W +: W] = W'(x);
      req_valid = NREQ'(1) << r;
      step();
      gcode = x ^ (x >> 1);
      check("b2g", int'(out_data), gcode);
      req_mode[r] = 1'b1;
      req_data[r*W +: W] = W'(gcode);
      step();
      check("g2b_roundtrip", int'(out_data), x);
    end

    // Randomized traffic; requests stay stable until accepted.
    req_valid = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom % 2 == 1)) begin
          req_valid[i] = 1'b1;
          req_mode[i]  = 1'($urandom);
          req_data[i*W +: W] = W'($urandom);
        end else if (!req_valid[i]) begin
          req_data[i*W +: W] = W'($urandom);
        end
      end
      out_ready = ($urandom % 10) < 7;
      rst_n     = ($urandom % 64) != 0;
      step();
      if (m_grant >= 0) req_valid[m_grant] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
